// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end: column scan, row synchronizer, press/release
// debounce, and key-to-code mapping with a one-cycle digit strobe.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_WAIT_RELEASE
  } state_t;

  state_t          state;
  logic [3:0]      row_m;
  logic [3:0]      row_s;
  logic [DW-1:0]   div_cnt;
  logic            sample;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic [CW-1:0]   match_cnt;
  logic [CW-1:0]   rel_cnt;
  logic            row_single;
  logic            row_idle;
  logic [1:0]      hit_idx;
  logic [1:0]      cur_col;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
  endfunction

  always_comb begin
    row_single = 1'b1;
    hit_idx    = 2'd0;
    case (row_s)
      4'b1110: hit_idx = 2'd0;
      4'b1101: hit_idx = 2'd1;
      4'b1011: hit_idx = 2'd2;
      4'b0111: hit_idx = 2'd3;
      default: row_single = 1'b0;
    endcase
  end

  assign row_idle = (row_s == 4'hF);

  always_comb begin
    cur_col = 2'd0;
    case (col)
      4'b1101: cur_col = 2'd1;
      4'b1011: cur_col = 2'd2;
      4'b0111: cur_col = 2'd3;
      default: cur_col = 2'd0;
    endcase
  end

  assign sample = (div_cnt == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_m   <= '1;
      row_s   <= '1;
      div_cnt <= '0;
    end else begin
      row_m   <= row;
      row_s   <= row_m;
      div_cnt <= sample ? '0 : div_cnt + DW'(1);
    end
  end

  // Decisions happen only on sample cycles; the strobe self-clears every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_SCAN;
      col         <= 4'b1110;
      digit       <= 4'h0;
      digit_valid <= 1'b0;
      key_held    <= 1'b0;
      row_idx     <= 2'd0;
      col_idx     <= 2'd0;
      match_cnt   <= '0;
      rel_cnt     <= '0;
    end else begin
      digit_valid <= 1'b0;
      if (sample) begin
        case (state)
          S_SCAN: begin
            if (row_single) begin
              row_idx   <= hit_idx;
              col_idx   <= cur_col;
              match_cnt <= CW'(1);
              if (DEBOUNCE == 1) begin
                digit       <= key_code(hit_idx, cur_col);
                digit_valid <= 1'b1;
                key_held    <= 1'b1;
                rel_cnt     <= '0;
                state       <= S_WAIT_RELEASE;
              end else begin
                state <= S_DEBOUNCE;
              end
            end else begin
              col <= {col[2:0], col[3]};
            end
          end
          S_DEBOUNCE: begin
            if (row_single && hit_idx == row_idx) begin
              if (match_cnt == CW'(DEBOUNCE - 1)) begin
                match_cnt   <= CW'(DEBOUNCE);
                digit       <= key_code(row_idx, col_idx);
                digit_valid <= 1'b1;
                key_held    <= 1'b1;
                rel_cnt     <= '0;
                state       <= S_WAIT_RELEASE;
              end else begin
                match_cnt <= match_cnt + CW'(1);
              end
            end else begin
              match_cnt <= '0;
              col       <= {col[2:0], col[3]};
              state     <= S_SCAN;
            end
          end
          S_WAIT_RELEASE: begin
            if (row_idle) begin
              if (rel_cnt == CW'(DEBOUNCE - 1)) begin
                key_held  <= 1'b0;
                rel_cnt   <= '0;
                match_cnt <= '0;
                col       <= {col[2:0], col[3]};
                state     <= S_SCAN;
              end else begin
                rel_cnt <= rel_cnt + CW'(1);
              end
            end else begin
              rel_cnt <= '0;
            end
          end
          default: state <= S_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: behavioural keypad matrix, key-map table,
// and timed sequences for debounce, multi-key, hold and reset corners.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] digit;
  logic       digit_valid;
  logic       key_held;
  logic [15:0] pressed;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic dv_prev = 1'b0;

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .digit(digit), .digit_valid(digit_valid), .key_held(key_held)
  );

  // Passive matrix: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (dv_prev) begin
      checks++;
      if (digit_valid !== 1'b0) begin
        errors++;
        $display("FAIL strobe_width: digit_valid=%b expected 0", digit_valid);
      end
    end
    if (digit_valid && !dv_prev) pulses++;
    dv_prev = digit_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_col(input logic [3:0] target, input string name);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = col;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk);
      #1;
      if (col == target && prev != target) found = 1'b1;
      prev = col;
    end
    chk(name, found, 1);
  endtask

  task automatic wait_strobe(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (digit_valid) found = 1'b1;
    end
  endtask

  task automatic wait_release(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (!key_held) found = 1'b1;
    end
  endtask

  task automatic press(input int r, input int c);
    pressed[r*4+c] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   f;
    int   p0;
    int   cnt;
    logic [3:0] prev;

    tbl[0]  = '{0, 0, 4'h1}; tbl[1]  = '{0, 1, 4'h2};
    tbl[2]  = '{0, 2, 4'h3}; tbl[3]  = '{0, 3, 4'hA};
    tbl[4]  = '{1, 0, 4'h4}; tbl[5]  = '{1, 1, 4'h5};
    tbl[6]  = '{1, 2, 4'h6}; tbl[7]  = '{1, 3, 4'hB};
    tbl[8]  = '{2, 0, 4'h7}; tbl[9]  = '{2, 1, 4'h8};
    tbl[10] = '{2, 2, 4'h9}; tbl[11] = '{2, 3, 4'hC};
    tbl[12] = '{3, 0, 4'hE}; tbl[13] = '{3, 1, 4'h0};
    tbl[14] = '{3, 2, 4'hF}; tbl[15] = '{3, 3, 4'hD};

    // Reset values and free-running column rotation
    pressed = '0;
    reset   = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_digit", digit, 4'h0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_held", key_held, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) chk("col_edge3", col, 4'b1110);
    @(posedge clk);
    @(negedge clk) chk("col_edge4", col, 4'b1101);
    repeat (11) @(posedge clk);
    @(negedge clk) chk("col_edge15", col, 4'b0111);
    @(posedge clk);
    @(negedge clk) chk("col_edge16", col, 4'b1110);

    // Clean press of '5' with exact press and release timing
    wait_col(4'b1101, "five_col1");
    press(1, 1);
    repeat (11) @(posedge clk);
    @(negedge clk) chk("five_early", digit_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("five_valid", digit_valid, 1);
    chk("five_digit", digit, 4'h5);
    chk("five_held", key_held, 1);
    @(posedge clk);
    @(negedge clk);
    chk("five_valid_off", digit_valid, 0);
    chk("five_digit_hold", digit, 4'h5);
    repeat (27) @(posedge clk);
    #1 pressed = '0;
    repeat (11) @(posedge clk);
    @(negedge clk) chk("five_held_late", key_held, 1);
    @(posedge clk);
    @(negedge clk);
    chk("five_released", key_held, 0);
    chk("five_col_next", col, 4'b1011);

    // Key map table
    for (int i = 0; i < 16; i++) begin
      press(tbl[i].r, tbl[i].c);
      wait_strobe(100, f);
      chk($sformatf("map%0d_seen", i), f, 1);
      chk($sformatf("map%0d_digit", i), digit, tbl[i].code);
      chk($sformatf("map%0d_held", i), key_held, 1);
      pressed = '0;
      wait_release(100, f);
      chk($sformatf("map%0d_rel", i), f, 1);
    end

    // Bounce on '1': one low sample, one idle, then stable
    wait_col(4'b1110, "bounce_col0");
    p0 = pulses;
    press(0, 0);
    repeat (4) @(posedge clk);
    #1 pressed = '0;
    repeat (4) @(posedge clk);
    #1 press(0, 0);
    repeat (8) @(posedge clk);
    @(negedge clk) #1 chk("bounce_no_strobe", pulses, p0);
    repeat (15) @(posedge clk);
    @(negedge clk) chk("bounce_early", digit_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("bounce_valid", digit_valid, 1);
    chk("bounce_digit", digit, 4'h1);
    #1 chk("bounce_one_pulse", pulses, p0 + 1);
    pressed = '0;
    wait_release(100, f);
    chk("bounce_rel", f, 1);

    // Multi-key on col3 never reported, scanning continues
    p0 = pulses;
    press(0, 3);
    press(2, 3);
    cnt  = 0;
    prev = col;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (col != prev) cnt++;
      prev = col;
    end
    chk("multi_rotations", cnt, 20);
    chk("multi_no_strobe", pulses, p0);
    pressed = '0;
    press(3, 2);
    wait_strobe(100, f);
    chk("hash_seen", f, 1);
    chk("hash_digit", digit, 4'hF);
    pressed = '0;
    wait_release(100, f);
    chk("hash_rel", f, 1);

    // Hold '0', add '8' on the same column, release both
    press(3, 1);
    wait_strobe(100, f);
    chk("hold_seen", f, 1);
    chk("hold_digit", digit, 4'h0);
    press(2, 1);
    #1 p0 = pulses;
    repeat (40) @(posedge clk);
    #1;
    chk("hold_held", key_held, 1);
    chk("hold_no_second", pulses, p0);
    chk("hold_digit_kept", digit, 4'h0);
    pressed = '0;
    repeat (11) @(posedge clk);
    @(negedge clk) chk("hold_held_late", key_held, 1);
    @(posedge clk);
    @(negedge clk) chk("hold_released", key_held, 0);

    // Reset during a strobe clears outputs asynchronously
    press(0, 1);
    wait_strobe(100, f);
    chk("rstA_seen", f, 1);
    #2 reset = 1'b0;
    #1;
    chk("rstA_valid", digit_valid, 0);
    chk("rstA_held", key_held, 0);
    chk("rstA_col", col, 4'b1110);
    chk("rstA_digit", digit, 4'h0);
    pressed = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset after two matching samples of 'D', key kept held
    wait_col(4'b0111, "rstB_col3");
    press(3, 3);
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    p0 = pulses;
    #1 chk("rstB_col", col, 4'b1110);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (23) @(posedge clk);
    @(negedge clk);
    chk("rstB_early", digit_valid, 0);
    chk("rstB_no_strobe", pulses, p0);
    @(posedge clk);
    @(negedge clk);
    chk("rstB_valid", digit_valid, 1);
    chk("rstB_digit", digit, 4'hD);
    pressed = '0;
    wait_release(100, f);
    chk("rstB_rel", f, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
